// File: rtl/grid_serial_dump.sv
// Serial readout of the grid word: snapshot on request, then shift out MSB first
// over a VALID/READY link, with an optional trailing even-parity bit.
module grid_serial_dump #(
    parameter int DATA_SIZE = 64,
    parameter int PARITY_EN = 0
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic [DATA_SIZE-1:0] GRID_IN,
    input  logic                 DUMP_REQ,
    input  logic                 ABORT,
    input  logic                 SERIAL_READY,
    output logic                 SERIAL_OUT,
    output logic                 SERIAL_VALID,
    output logic                 FRAME_START,
    output logic                 BUSY,
    output logic                 DONE
);

    localparam int              CNT_W    = $clog2(DATA_SIZE + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_SIZE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic            PAR_ON   = (PARITY_EN != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [DATA_SIZE-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 par_q, par_d;
    logic                 serial_valid_q, serial_valid_d;
    logic                 frame_start_q, frame_start_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic xfer;
    logic last_data;

    assign xfer      = serial_valid_q & SERIAL_READY;
    assign last_data = (cnt_q == CNT_ONE);

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ABORT outranks a simultaneous transfer
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (DUMP_REQ) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (ABORT) begin
                    state_d = ST_IDLE;
                end else if (xfer && last_data) begin
                    state_d = PAR_ON ? ST_PARITY : ST_IDLE;
                end
            end
            ST_PARITY: begin
                if (ABORT || xfer) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        shadow_d       = shadow_q;
        cnt_d          = cnt_q;
        par_d          = par_q;
        serial_valid_d = serial_valid_q;
        frame_start_d  = frame_start_q;
        busy_d         = busy_q;
        done_d         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                serial_valid_d = 1'b0;
                frame_start_d  = 1'b0;
                busy_d         = 1'b0;
                if (DUMP_REQ) begin
                    shadow_d       = GRID_IN;
                    cnt_d          = CNT_FULL;
                    par_d          = ^GRID_IN;
                    serial_valid_d = 1'b1;
                    frame_start_d  = 1'b1;
                    busy_d         = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (ABORT) begin
                    shadow_d       = '0;
                    serial_valid_d = 1'b0;
                    frame_start_d  = 1'b0;
                    busy_d         = 1'b0;
                end else if (xfer) begin
                    frame_start_d = 1'b0;
                    cnt_d         = cnt_q - CNT_ONE;
                    if (last_data) begin
                        // The parity bit rides in the shadow MSB so SERIAL_OUT stays a plain flop tap
                        shadow_d                = '0;
                        shadow_d[DATA_SIZE-1]   = par_q & PAR_ON;
                        if (!PAR_ON) begin
                            serial_valid_d = 1'b0;
                            busy_d         = 1'b0;
                            done_d         = 1'b1;
                        end
                    end else begin
                        shadow_d = {shadow_q[DATA_SIZE-2:0], 1'b0};
                    end
                end
            end
            ST_PARITY: begin
                if (ABORT) begin
                    shadow_d       = '0;
                    serial_valid_d = 1'b0;
                    frame_start_d  = 1'b0;
                    busy_d         = 1'b0;
                end else if (xfer) begin
                    shadow_d       = '0;
                    serial_valid_d = 1'b0;
                    busy_d         = 1'b0;
                    done_d         = 1'b1;
                end
            end
            default: begin
                shadow_d       = '0;
                serial_valid_d = 1'b0;
                frame_start_d  = 1'b0;
                busy_d         = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            shadow_q       <= '0;
            cnt_q          <= '0;
            par_q          <= 1'b0;
            serial_valid_q <= 1'b0;
            frame_start_q  <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            shadow_q       <= shadow_d;
            cnt_q          <= cnt_d;
            par_q          <= par_d;
            serial_valid_q <= serial_valid_d;
            frame_start_q  <= frame_start_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    assign SERIAL_OUT   = shadow_q[DATA_SIZE-1];
    assign SERIAL_VALID = serial_valid_q;
    assign FRAME_START  = frame_start_q;
    assign BUSY         = busy_q;
    assign DONE         = done_q;

endmodule

// File: tb/tb_grid_serial_dump.sv
// Bench for grid_serial_dump: three instances (8-bit, 8-bit with parity, 64-bit)
// checked every cycle against a bit-list model, plus directed literal checks.
module tb_grid_serial_dump;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [63:0] grid;
    logic        req, abort, ready;
    logic [2:0]  so, sv, fs, bz, dn;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    grid_serial_dump #(.DATA_SIZE(8), .PARITY_EN(0)) dut0 (
        .CLK(CLK), .RESET_N(RESET_N), .GRID_IN(grid[7:0]), .DUMP_REQ(req), .ABORT(abort),
        .SERIAL_READY(ready), .SERIAL_OUT(so[0]), .SERIAL_VALID(sv[0]), .FRAME_START(fs[0]),
        .BUSY(bz[0]), .DONE(dn[0]));
    grid_serial_dump #(.DATA_SIZE(8), .PARITY_EN(1)) dut1 (
        .CLK(CLK), .RESET_N(RESET_N), .GRID_IN(grid[7:0]), .DUMP_REQ(req), .ABORT(abort),
        .SERIAL_READY(ready), .SERIAL_OUT(so[1]), .SERIAL_VALID(sv[1]), .FRAME_START(fs[1]),
        .BUSY(bz[1]), .DONE(dn[1]));
    grid_serial_dump #(.DATA_SIZE(64), .PARITY_EN(0)) dut2 (
        .CLK(CLK), .RESET_N(RESET_N), .GRID_IN(grid), .DUMP_REQ(req), .ABORT(abort),
        .SERIAL_READY(ready), .SERIAL_OUT(so[2]), .SERIAL_VALID(sv[2]), .FRAME_START(fs[2]),
        .BUSY(bz[2]), .DONE(dn[2]));

    // Model: each dump is the ordered list of bits to send, plus a cursor into it
    logic [64:0] mbits [3];
    int          mlen  [3];
    int          mpos  [3];
    bit          mbusy [3];
    bit          mdone [3];
    logic [63:0] msnap [3];

    function automatic int wid(input int i);
        return (i == 2) ? 64 : 8;
    endfunction

    function automatic int par(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input int inst, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d got=%h want=%h t=%0t", name, inst, act, exp, $time);
        end
    endtask

    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 3; i++) begin
                mbusy[i] = 0; mdone[i] = 0; mpos[i] = 0; mlen[i] = 0;
                mbits[i] = '0; msnap[i] = '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                mdone[i] = 0;
                if (!mbusy[i]) begin
                    if (req) begin
                        int  w;
                        bit  p;
                        w = wid(i);
                        p = 0;
                        mbits[i] = '0;
                        msnap[i] = '0;
                        for (int b = 0; b < w; b++) begin
                            mbits[i][b] = grid[w-1-b];
                            msnap[i][b] = grid[b];
                            p = p ^ grid[b];
                        end
                        if (par(i) != 0) mbits[i][w] = p;
                        mlen[i]  = w + par(i);
                        mpos[i]  = 0;
                        mbusy[i] = 1;
                    end
                end else if (abort) begin
                    mbusy[i] = 0;
                end else if (ready) begin
                    mpos[i] = mpos[i] + 1;
                    if (mpos[i] == mlen[i]) begin
                        mbusy[i] = 0;
                        mdone[i] = 1;
                    end
                end
            end
        end
    end

    // Per-cycle compare, plus a deserializer standing in for the loader on the 64-bit path
    logic [63:0] rx;
    int          rxn;
    initial begin rx = '0; rxn = 0; end

    always @(negedge CLK) begin
        for (int i = 0; i < 3; i++) begin
            chk("valid", i, 64'(sv[i]), 64'(mbusy[i]));
            chk("busy",  i, 64'(bz[i]), 64'(mbusy[i]));
            chk("frame", i, 64'(fs[i]), 64'(mbusy[i] && mpos[i] == 0));
            chk("done",  i, 64'(dn[i]), 64'(mdone[i]));
            if (mbusy[i]) chk("out", i, 64'(so[i]), 64'(mbits[i][mpos[i]]));
            if (dn[i]) $display("dump complete inst=%0d word=%h t=%0t", i, msnap[i], $time);
        end
        if (sv[2] && ready) begin
            if (fs[2]) begin rx = '0; rxn = 0; end
            rx  = {rx[62:0], so[2]};
            rxn = rxn + 1;
        end
        if (dn[2] && RESET_N) begin
            chk("roundtrip_word",  2, rx, msnap[2]);
            chk("roundtrip_count", 2, 64'(rxn), 64'd64);
        end
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic capture(input int inst, output logic [8:0] w, output int nb, output int nd,
                           output int dc, output int nf, output int fc);
        w = '0; nb = 0; nd = 0; dc = 0; nf = 0; fc = 0;
        req = 1'b1;
        step();
        req = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge CLK);
            if (sv[inst]) begin w = {w[7:0], so[inst]}; nb++; end
            if (fs[inst]) begin nf++; fc = n; end
            if (dn[inst]) begin nd++; dc = n; end
        end
        step();
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((bz[0] || bz[1]) && k < 200) begin step(); k++; end
        chk("idle_timeout", 0, 64'(bz[0] | bz[1]), 64'd0);
    endtask

    logic [8:0] w;
    int nb, nd, dc, nf, fc;

    initial begin
        RESET_N = 1'b0; grid = '0; req = 1'b0; abort = 1'b0; ready = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_outputs", 0, 64'({so, sv, fs, bz, dn}), 64'd0);
        #1;
        RESET_N = 1'b1;
        step();

        // Plain dump of A5 with READY tied high
        grid = 64'h0123456789ABCDA5; ready = 1'b1;
        capture(0, w, nb, nd, dc, nf, fc);
        chk("a5_word",       0, 64'(w[7:0]), 64'hA5);
        chk("a5_bits",       0, 64'(nb), 64'd8);
        chk("a5_done_count", 0, 64'(nd), 64'd1);
        chk("a5_done_cycle", 0, 64'(dc), 64'd9);
        chk("a5_frame_cnt",  0, 64'(nf), 64'd1);
        chk("a5_frame_cyc",  0, 64'(fc), 64'd1);

        // Parity instance: A4 has three ones, so the trailing bit is 1
        grid = 64'hFEDCBA98765432A4;
        capture(1, w, nb, nd, dc, nf, fc);
        chk("a4p_word",       1, 64'(w), 64'h149);
        chk("a4p_bits",       1, 64'(nb), 64'd9);
        chk("a4p_done_count", 1, 64'(nd), 64'd1);
        chk("a4p_done_cycle", 1, 64'(dc), 64'd10);

        // Reset mid-dump: outputs clear immediately, no DONE afterwards
        wait_idle();
        grid = {$urandom, $urandom};
        req = 1'b1; step(); req = 1'b0;
        step(); step();
        chk("busy_before_reset", 0, 64'(bz[0]), 64'd1);
        RESET_N = 1'b0;
        #1;
        chk("async_reset", 0, 64'({so, sv, fs, bz, dn}), 64'd0);
        step();
        RESET_N = 1'b1;
        repeat (4) step();

        // Backpressure with GRID_IN churning during the dump
        req = 1'b1; step(); req = 1'b0;
        for (int n = 0; n < 40; n++) begin
            ready = 1'($urandom_range(0, 1));
            grid  = {$urandom, $urandom};
            step();
        end

        // Abort after three transfers, in the same cycle as READY
        ready = 1'b1;
        wait_idle();
        grid = 64'h00000000000000C3;
        req = 1'b1; step(); req = 1'b0;
        step(); step(); step();
        abort = 1'b1; step(); abort = 1'b0;
        @(negedge CLK);
        chk("abort_busy", 0, 64'(bz[0]), 64'd0);
        chk("abort_done", 0, 64'(dn[0]), 64'd0);
        step();
        // ABORT and DUMP_REQ together in IDLE: request wins, restart at MSB
        grid = 64'h000000000000005A;
        req = 1'b1; abort = 1'b1; step(); req = 1'b0; abort = 1'b0;
        @(negedge CLK);
        chk("restart_busy",  0, 64'(bz[0]), 64'd1);
        chk("restart_frame", 0, 64'(fs[0]), 64'd1);
        chk("restart_msb",   0, 64'(so[0]), 64'd0);
        step();

        // DUMP_REQ held high: back-to-back dumps
        req = 1'b1;
        for (int n = 0; n < 60; n++) begin
            ready = ($urandom_range(0, 3) != 0);
            grid  = {$urandom, $urandom};
            step();
        end
        req = 1'b0;

        // Random traffic
        for (int n = 0; n < 800; n++) begin
            req   = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 59) == 0);
            ready = ($urandom_range(0, 3) != 0);
            grid  = {$urandom, $urandom};
            step();
        end
        req = 1'b0; abort = 1'b0; ready = 1'b1;
        repeat (80) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
